inv_kin_seq_ctrl: RTL and testbench

//  Upstream sequencer/collector wrapped around the inverse-kinematics datapath.

---
 rtl/inv_kin_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_inv_kin_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_kin_seq_ctrl.sv
// Sequencer around the inverse-kinematics datapath: FIFO-buffered targets, fixed settle, captured result.
// Optional reach check compiled in with INV_KIN_RANGE_CHK_EN.
module inv_kin_seq_ctrl #(
    parameter int unsigned BIT_WIDTH     = 32,
    parameter int unsigned FRACTIONS     = 15,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 128
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIT_WIDTH-1:0]         in_x,
    input  logic [BIT_WIDTH-1:0]         in_y,
    output logic [BIT_WIDTH-1:0]         kin_x,
    output logic [BIT_WIDTH-1:0]         kin_y,
    input  logic [BIT_WIDTH-1:0]         kin_theta1,
    input  logic [BIT_WIDTH-1:0]         kin_theta2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BIT_WIDTH-1:0]         out_theta1,
    output logic [BIT_WIDTH-1:0]         out_theta2,
    output logic                         out_err,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (FRACTIONS >= BIT_WIDTH - 1 || SETTLE_CYCLES < 1) begin : g_bad_format
        $error("FRACTIONS must leave integer bits and SETTLE_CYCLES must be nonzero");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StSettle, StCapture, StHold} state_e;

    state_e               state_q;
    logic [SET_W-1:0]     settle_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [BIT_WIDTH-1:0] mem_x [FIFO_DEPTH];
    logic [BIT_WIDTH-1:0] mem_y [FIFO_DEPTH];
    logic                 push;
    logic                 pop;

    // A pop in LOAD frees a slot, so a full FIFO may still accept in that cycle.
    assign pop        = (state_q == StLoad);
    assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH)) || pop;
    assign push       = in_valid && in_ready;
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem_x[wr_ptr_q] <= in_x;
            mem_y[wr_ptr_q] <= in_y;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

`ifdef INV_KIN_RANGE_CHK_EN
    localparam logic [BIT_WIDTH-2:0] REACH_LIMIT = (BIT_WIDTH-1)'(23 << FRACTIONS);

    logic err_q;
    logic head_oor;

    // Magnitude only; the sign bit is ignored.
    assign head_oor = (mem_x[rd_ptr_q][BIT_WIDTH-2:0] >= REACH_LIMIT) ||
                      (mem_y[rd_ptr_q][BIT_WIDTH-2:0] >= REACH_LIMIT);
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            settle_q   <= '0;
            kin_x      <= '0;
            kin_y      <= '0;
            out_valid  <= 1'b0;
            out_theta1 <= '0;
            out_theta2 <= '0;
`ifdef INV_KIN_RANGE_CHK_EN
            err_q      <= 1'b0;
            out_err    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (count_q != '0) state_q <= StLoad;
                end
                StLoad: begin
                    kin_x    <= mem_x[rd_ptr_q];
                    kin_y    <= mem_y[rd_ptr_q];
                    settle_q <= '0;
`ifdef INV_KIN_RANGE_CHK_EN
                    err_q    <= head_oor;
                    state_q  <= head_oor ? StCapture : StSettle;
`else
                    state_q  <= StSettle;
`endif
                end
                StSettle: begin
                    settle_q <= settle_q + SET_W'(1);
                    if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_q <= StCapture;
                end
                StCapture: begin
                    out_valid  <= 1'b1;
`ifdef INV_KIN_RANGE_CHK_EN
                    out_theta1 <= err_q ? '0 : kin_theta1;
                    out_theta2 <= err_q ? '0 : kin_theta2;
                    out_err    <= err_q;
`else
                    out_theta1 <= kin_theta1;
                    out_theta2 <= kin_theta2;
`endif
                    state_q    <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= (count_q != '0) ? StLoad : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_kin_seq_ctrl.sv
// Bench for inv_kin_seq_ctrl: queue-based transaction model checked every cycle plus directed literal pins.
module tb_inv_kin_seq_ctrl;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SC    = 128;
`ifdef INV_KIN_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic        in_ready, out_valid, out_err, busy;
    logic [31:0] kin_x, kin_y, kin_theta1, kin_theta2, out_theta1, out_theta2;
    logic [2:0]  fifo_count;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          handshakes = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (rst && out_valid && out_ready) handshakes <= handshakes + 1;

    // Stand-in datapath whose outputs move every cycle, so capture timing is observable.
    assign kin_theta1 = kin_x + cyc;
    assign kin_theta2 = kin_y - cyc;

    inv_kin_seq_ctrl #(
        .BIT_WIDTH    (32),
        .FRACTIONS    (15),
        .FIFO_DEPTH   (DEPTH),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .kin_x     (kin_x),
        .kin_y     (kin_y),
        .kin_theta1(kin_theta1),
        .kin_theta2(kin_theta2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_theta1(out_theta1),
        .out_theta2(out_theta2),
        .out_err   (out_err),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed { logic [31:0] x; logic [31:0] y; } tgt_t;
    tgt_t        q[$];
    bit          m_loading = 0, m_active = 0, m_ov = 0, m_err = 0, m_perr = 0;
    int          m_age = 0, m_len = 0;
    logic [31:0] m_kx = '0, m_ky = '0, m_t1 = '0, m_t2 = '0;

    function automatic bit oor(input logic [31:0] v);
        logic [30:0] mag;
        mag = v[30:0];
        return RANGE_CHK && (mag >= 31'h000B8000);
    endfunction

    always @(posedge clock or negedge rst) begin : model
        int   qs;
        bit   pop, rdy, push, nxt;
        tgt_t e;
        if (!rst) begin
            q.delete();
            m_loading = 0; m_active = 0; m_ov = 0; m_err = 0; m_perr = 0;
            m_age = 0; m_len = 0;
            m_kx = '0; m_ky = '0; m_t1 = '0; m_t2 = '0;
        end else begin
            qs   = q.size();
            pop  = m_loading;
            rdy  = (qs < DEPTH) || pop;
            push = in_valid && rdy;
            nxt  = (qs > 0) && ((!m_active && !m_ov && !m_loading) || (m_ov && out_ready));
            if (m_ov && out_ready) m_ov = 0;
            if (m_active) begin
                if (m_age == m_len) begin
                    m_ov = 1; m_active = 0; m_err = m_perr;
                    m_t1 = m_perr ? 32'h0 : m_kx + cyc;
                    m_t2 = m_perr ? 32'h0 : m_ky - cyc;
                end else begin
                    m_age++;
                end
            end
            if (pop) begin
                e = q.pop_front();
                m_kx = e.x; m_ky = e.y;
                m_perr = oor(e.x) || oor(e.y);
                m_len = m_perr ? 1 : SC + 1;
                m_age = 1; m_active = 1;
            end
            if (push) q.push_back({in_x, in_y});
            m_loading = nxt;
        end
    end

    always @(negedge clock) begin
        chk("in_ready", in_ready, ((q.size() < DEPTH) || m_loading));
        chk("fifo_count", fifo_count, q.size());
        chk("kin_x", kin_x, m_kx);
        chk("kin_y", kin_y, m_ky);
        chk("out_valid", out_valid, m_ov);
        chk("out_theta1", out_theta1, m_t1);
        chk("out_theta2", out_theta2, m_t2);
        chk("out_err", out_err, m_err);
        chk("busy", busy, (m_loading || m_active || m_ov || q.size() > 0));
    end

    // ---------------- stimulus ----------------
    task automatic push_tgt(input logic [31:0] x, input logic [31:0] y);
        in_x = x; in_y = y; in_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock); #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL push_timeout actual=no_handshake required=in_ready within 2000 cycles");
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clock); n++;
            @(negedge clock);
            if (out_valid) return;
        end
        checks++; errors++;
        $display("FAIL wait_out actual=no_out_valid required=out_valid within %0d edges", limit);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (!busy) begin
                @(posedge clock); #1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_idle actual=busy required=idle within %0d cycles", limit);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          n;
        int unsigned c0;
        int          hs0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_kin_x", kin_x, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        @(posedge clock); #1;

        // Single target latency and capture values
        out_ready = 1'b1;
        push_tgt(32'h000A0000, 32'h00050000);
        @(negedge clock); c0 = cyc;
        wait_out(400, n);
        chk("t1_latency", n, SC + 3);
        chk("t1_theta1", out_theta1, 32'h000A0000 + c0 + 130);
        chk("t1_theta2", out_theta2, 32'h00050000 - (c0 + 130));
        chk("t1_err", out_err, 0);
        wait_idle(400);

        // Fill while result is held, then push into a full FIFO during a pop
        hs0 = handshakes;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_tgt(32'(i) << 16, (32'(i) << 15) | 32'h100);
        wait_out(400, n);
        chk("t2_full_count", fifo_count, 4);
        chk("t2_full_ready", in_ready, 0);
        in_x = 32'h00060000; in_y = 32'h00030000; in_valid = 1'b1;
        repeat (10) begin
            @(negedge clock);
            chk("t2_stall_ready", in_ready, 0);
            chk("t2_hold_valid", out_valid, 1);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        push_tgt(32'h00060000, 32'h00030000);
        @(negedge clock);
        chk("t3_wrap_count", fifo_count, 4);
        wait_idle(2000);
        chk("t2_result_count", handshakes - hs0, 6);

        // Reset mid-SETTLE with two entries queued
        push_tgt(32'h00010000, 32'h00010000);
        push_tgt(32'h00020000, 32'h00020000);
        push_tgt(32'h00030000, 32'h00030000);
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("t4_pre_count", fifo_count, 2);
        @(posedge clock); #1;
        rst = 1'b0;
        #1;
        chk("t4_rst_valid", out_valid, 0);
        chk("t4_rst_count", fifo_count, 0);
        chk("t4_rst_kin_x", kin_x, 0);
        repeat (2) @(posedge clock);
        @(negedge clock); rst = 1'b1;
        @(posedge clock); #1;
        push_tgt(32'h00038000, 32'h80024000);
        @(negedge clock); c0 = cyc;
        wait_out(400, n);
        chk("t4_latency", n, SC + 3);
        chk("t4_theta1", out_theta1, 32'h00038000 + c0 + 130);
        chk("t4_theta2", out_theta2, 32'h80024000 - (c0 + 130));
        wait_idle(400);

        // Out-of-reach target, then a legal one
        push_tgt(32'h000C0000, 32'h0);
        @(negedge clock); c0 = cyc;
        wait_out(400, n);
        chk("t5_latency", n, RANGE_CHK ? 3 : SC + 3);
        chk("t5_err", out_err, RANGE_CHK);
        chk("t5_theta1", out_theta1, RANGE_CHK ? 32'h0 : 32'h000C0000 + c0 + n - 1);
        chk("t5_theta2", out_theta2, RANGE_CHK ? 32'h0 : 32'h0 - (c0 + n - 1));
        wait_idle(400);
        push_tgt(32'h00020000, 32'h00030000);
        wait_out(400, n);
        chk("t5_legal_err", out_err, 0);
        chk("t5_legal_latency", n, SC + 3);
        wait_idle(400);

        // Reach boundaries with a stuttering consumer
        out_ready = 1'b0;
        push_tgt(32'h000B8000, 32'h0);
        push_tgt(32'h000B7FFF, 32'h000B7FFF);
        push_tgt(32'h00010000, 32'h800C0000);
        push_tgt(32'h80001000, 32'h00004000);
        wait_out(400, n);
        chk("t7_edge_err", out_err, RANGE_CHK);
        chk("t7_edge_kin_x", kin_x, 32'h000B8000);
        for (int i = 0; i < 600; i++) begin
            @(posedge clock); #1;
            out_ready = (i % 3 != 1);
        end
        out_ready = 1'b1;
        wait_idle(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
